// File: rtl/ca_code_search.sv
// ca_code_search
//   Serial code-phase search and lock for one GPS L1 C/A PRN. Regenerates the
//   local Gold-code replica, correlates over 1023-chip periods and slips the
//   replica one chip per failed period until lock or the slip budget runs out.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start, prn      : begin a search for prn (1..32); prn sampled on start
//   chip_valid      : qualifies chip_in
//   chip_in         : hard-decision received chip
//   busy            : search or tracking in progress
//   locked          : replica aligned with input
//   inverted        : lock on the complemented code
//   fail            : search exhausted or prn invalid (sticky until start/rst)
//   code_phase      : slips performed so far
//   corr            : agreement count of the last completed period
//   corr_valid      : one-cycle pulse at each period end
//   local_chip      : current replica chip
module ca_code_search #(
  parameter int unsigned LOCK_THRESH = 900,
  parameter int unsigned MAX_SLIPS   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  prn,
  input  logic        chip_valid,
  input  logic        chip_in,
  output logic        busy,
  output logic        locked,
  output logic        inverted,
  output logic        fail,
  output logic [9:0]  code_phase,
  output logic [10:0] corr,
  output logic        corr_valid,
  output logic        local_chip
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CORR, S_SLIP, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [10:0] HI_THRESH  = 11'(LOCK_THRESH);
  localparam logic [10:0] LO_THRESH  = 11'(1023 - LOCK_THRESH);
  localparam logic [9:0]  SLIP_LIMIT = 10'(MAX_SLIPS);
  localparam logic [10:0] LAST_CHIP  = 11'd1022;

  // Bit (t-1) of the mask selects G2 stage t.
  function automatic logic [9:0] tap_pair(input int unsigned a, input int unsigned b);
    return (10'd1 << (a - 1)) | (10'd1 << (b - 1));
  endfunction

  function automatic logic [9:0] tap_mask(input logic [5:0] p);
    logic [9:0] m;
    m = '0;
    case (p)
      6'd1:  m = tap_pair(2, 6);
      6'd2:  m = tap_pair(3, 7);
      6'd3:  m = tap_pair(4, 8);
      6'd4:  m = tap_pair(5, 9);
      6'd5:  m = tap_pair(1, 9);
      6'd6:  m = tap_pair(2, 10);
      6'd7:  m = tap_pair(1, 8);
      6'd8:  m = tap_pair(2, 9);
      6'd9:  m = tap_pair(3, 10);
      6'd10: m = tap_pair(2, 3);
      6'd11: m = tap_pair(3, 4);
      6'd12: m = tap_pair(5, 6);
      6'd13: m = tap_pair(6, 7);
      6'd14: m = tap_pair(7, 8);
      6'd15: m = tap_pair(8, 9);
      6'd16: m = tap_pair(9, 10);
      6'd17: m = tap_pair(1, 4);
      6'd18: m = tap_pair(2, 5);
      6'd19: m = tap_pair(3, 6);
      6'd20: m = tap_pair(4, 7);
      6'd21: m = tap_pair(5, 8);
      6'd22: m = tap_pair(6, 9);
      6'd23: m = tap_pair(1, 3);
      6'd24: m = tap_pair(4, 6);
      6'd25: m = tap_pair(5, 7);
      6'd26: m = tap_pair(6, 8);
      6'd27: m = tap_pair(7, 9);
      6'd28: m = tap_pair(8, 10);
      6'd29: m = tap_pair(1, 6);
      6'd30: m = tap_pair(2, 7);
      6'd31: m = tap_pair(3, 8);
      6'd32: m = tap_pair(4, 9);
      default: m = '0;
    endcase
    return m;
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  g1_q, g1_d;      // g1_q[i] holds stage i+1
  logic [9:0]  g2_q, g2_d;
  logic [9:0]  mask_q, mask_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] agree_q, agree_d;
  logic [9:0]  slips_q, slips_d;
  logic [10:0] corr_q, corr_d;
  logic        corr_valid_q, corr_valid_d;
  logic        locked_q, locked_d;
  logic        inverted_q, inverted_d;
  logic        fail_q, fail_d;
  logic        busy_q, busy_d;
  logic        local_chip_q, local_chip_d;

  logic        prn_ok;
  logic [10:0] agree_inc;
  logic [9:0]  g1_adv, g2_adv;

  always_comb begin
    prn_ok    = (prn >= 6'd1) && (prn <= 6'd32);
    agree_inc = agree_q + 11'(chip_in == local_chip_q);
    g1_adv    = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
    g2_adv    = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};

    state_d      = state_q;
    g1_d         = g1_q;
    g2_d         = g2_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    agree_d      = agree_q;
    slips_d      = slips_q;
    corr_d       = corr_q;
    corr_valid_d = 1'b0;
    locked_d     = locked_q;
    inverted_d   = inverted_q;
    fail_d       = fail_q;

    if (start) begin
      // Restart from any state; the IDLE decision is folded in here so that
      // LOAD (or FAIL for a bad prn) is reached in the cycle after start.
      locked_d   = 1'b0;
      inverted_d = 1'b0;
      if (prn_ok) begin
        state_d = S_LOAD;
        mask_d  = tap_mask(prn);
        fail_d  = 1'b0;
      end else begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE, S_FAIL: ;
        S_LOAD: begin
          g1_d    = '1;
          g2_d    = '1;
          cnt_d   = '0;
          agree_d = '0;
          slips_d = '0;
          state_d = S_CORR;
        end
        S_CORR, S_LOCKED: begin
          if (chip_valid) begin
            g1_d = g1_adv;
            g2_d = g2_adv;
            if (cnt_q == LAST_CHIP) begin
              cnt_d        = '0;
              agree_d      = '0;
              corr_d       = agree_inc;
              corr_valid_d = 1'b1;
              if (agree_inc >= HI_THRESH) begin
                state_d    = S_LOCKED;
                locked_d   = 1'b1;
                inverted_d = 1'b0;
              end else if (agree_inc <= LO_THRESH) begin
                state_d    = S_LOCKED;
                locked_d   = 1'b1;
                inverted_d = 1'b1;
              end else begin
                locked_d   = 1'b0;
                inverted_d = 1'b0;
                if (slips_q == SLIP_LIMIT) begin
                  state_d = S_FAIL;
                  fail_d  = 1'b1;
                end else begin
                  state_d = S_SLIP;
                end
              end
            end else begin
              cnt_d   = cnt_q + 11'd1;
              agree_d = agree_inc;
            end
          end
        end
        S_SLIP: begin
          // Swallow one input chip without advancing the replica.
          if (chip_valid) begin
            slips_d = (slips_q == SLIP_LIMIT) ? slips_q : slips_q + 10'd1;
            state_d = S_CORR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_CORR) ||
             (state_d == S_SLIP) || (state_d == S_LOCKED);
    // Registered copy of the replica chip for the next LFSR state.
    local_chip_d = (state_d == S_IDLE) ? 1'b0 : (g1_d[9] ^ (^(g2_d & mask_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      g1_q         <= '1;
      g2_q         <= '1;
      mask_q       <= '0;
      cnt_q        <= '0;
      agree_q      <= '0;
      slips_q      <= '0;
      corr_q       <= '0;
      corr_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      inverted_q   <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
      local_chip_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      g1_q         <= g1_d;
      g2_q         <= g2_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      agree_q      <= agree_d;
      slips_q      <= slips_d;
      corr_q       <= corr_d;
      corr_valid_q <= corr_valid_d;
      locked_q     <= locked_d;
      inverted_q   <= inverted_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      local_chip_q <= local_chip_d;
    end
  end

  assign busy       = busy_q;
  assign locked     = locked_q;
  assign inverted   = inverted_q;
  assign fail       = fail_q;
  assign code_phase = slips_q;
  assign corr       = corr_q;
  assign corr_valid = corr_valid_q;
  assign local_chip = local_chip_q;

endmodule

// File: tb/tb_ca_code_search.sv
// tb_ca_code_search
//   Directed bench for ca_code_search: one default instance (a_*) and one with
//   a four-slip budget (b_*), both fed from the same input stream.
module tb_ca_code_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, chip_valid, chip_in;
  logic [5:0]  prn;

  logic        a_busy, a_locked, a_inverted, a_fail, a_corr_valid, a_local_chip;
  logic [9:0]  a_code_phase;
  logic [10:0] a_corr;
  logic        b_busy, b_locked, b_inverted, b_fail, b_corr_valid, b_local_chip;
  logic [9:0]  b_code_phase;
  logic [10:0] b_corr;

  ca_code_search dut_a (
    .clk(clk), .rst(rst), .start(start), .prn(prn),
    .chip_valid(chip_valid), .chip_in(chip_in),
    .busy(a_busy), .locked(a_locked), .inverted(a_inverted), .fail(a_fail),
    .code_phase(a_code_phase), .corr(a_corr), .corr_valid(a_corr_valid),
    .local_chip(a_local_chip)
  );

  ca_code_search #(.LOCK_THRESH(900), .MAX_SLIPS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .prn(prn),
    .chip_valid(chip_valid), .chip_in(chip_in),
    .busy(b_busy), .locked(b_locked), .inverted(b_inverted), .fail(b_fail),
    .code_phase(b_code_phase), .corr(b_corr), .corr_valid(b_corr_valid),
    .local_chip(b_local_chip)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // G2 tap pairs for PRN 1..32 (index 0 unused).
  int t1_tab[33] = '{0, 2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int t2_tab[33] = '{0, 6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  task automatic make_code(input int p, output logic [1022:0] code);
    logic [10:1] g1, g2;
    logic f1, f2;
    g1 = '1;
    g2 = '1;
    for (int k = 0; k < 1023; k++) begin
      code[k] = g1[10] ^ g2[t1_tab[p]] ^ g2[t2_tab[p]];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      g1 = {g1[9:1], f1};
      g2 = {g2[9:1], f2};
    end
  endtask

  logic [1022:0] code_cur;
  int            delay_cur;
  bit            inv_cur;
  int            sidx;

  function automatic logic stream_chip(input int i);
    if (i < delay_cur) return 1'b0;
    return code_cur[(i - delay_cur) % 1023] ^ inv_cur;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, then the LOAD cycle with a junk chip that must be ignored.
  task automatic do_start(input logic [5:0] p);
    start = 1'b1;
    prn   = p;
    tick();
    start      = 1'b0;
    chip_valid = 1'b1;
    chip_in    = ~stream_chip(0);
    tick();
    chip_valid = 1'b0;
    sidx       = 0;
  endtask

  // mode 0: run until dut_a locks or fails; mode 1: run until a corr_valid pulse.
  task automatic run_a(input int max_chips, input bit gap, input int mode,
                       output int pulses);
    int n;
    bit done;
    n = 0;
    pulses = 0;
    done = 1'b0;
    while (!done && n < max_chips) begin
      if (gap) begin
        chip_valid = 1'b0;
        tick();
        if (a_corr_valid) pulses++;
      end
      chip_valid = 1'b1;
      chip_in    = stream_chip(sidx);
      tick();
      sidx++;
      n++;
      if (a_corr_valid) pulses++;
      if (mode == 0) done = a_locked || a_fail;
      else           done = a_corr_valid;
    end
    chip_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, inrange, n;
    rst = 1'b1; start = 1'b0; prn = '0; chip_valid = 1'b0; chip_in = 1'b0;
    delay_cur = 0; inv_cur = 1'b0; sidx = 0;
    code_cur = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy", a_busy, 0);
    check("rst_locked", a_locked, 0);
    check("rst_inverted", a_inverted, 0);
    check("rst_fail", a_fail, 0);
    check("rst_corr_valid", a_corr_valid, 0);
    check("rst_code_phase", a_code_phase, 0);
    check("rst_corr", a_corr, 0);
    check("rst_local_chip", a_local_chip, 0);

    // Aligned PRN31
    make_code(31, code_cur); delay_cur = 0; inv_cur = 1'b0;
    do_start(6'd31);
    check("load_busy", a_busy, 1);
    check("load_local_chip", a_local_chip, 1);
    run_a(1100, 1'b0, 0, pulses);
    check("p31_chips", sidx, 1023);
    check("p31_corr_valid", a_corr_valid, 1);
    check("p31_corr", a_corr, 1023);
    check("p31_locked", a_locked, 1);
    check("p31_inverted", a_inverted, 0);
    check("p31_code_phase", a_code_phase, 0);
    check("p31_pulses", pulses, 1);
    tick();
    check("p31_pulse_width", a_corr_valid, 0);

    // Reset mid-CORR
    do_start(6'd31);
    run_a(100, 1'b0, 1, pulses);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_corr", a_corr, 0);
    check("mid_rst_locked", a_locked, 0);
    check("mid_rst_local_chip", a_local_chip, 0);
    check("mid_rst_code_phase", a_code_phase, 0);

    // PRN2 delayed by 5 chips, chip_valid every other cycle
    make_code(2, code_cur); delay_cur = 5; inv_cur = 1'b0;
    do_start(6'd2);
    run_a(7000, 1'b1, 0, pulses);
    check("d5_chips", sidx, 5 * 1024 + 1023);
    check("d5_locked", a_locked, 1);
    check("d5_code_phase", a_code_phase, 5);
    check("d5_corr", a_corr, 1023);
    check("d5_pulses", pulses, 6);

    // Complemented aligned PRN5
    make_code(5, code_cur); delay_cur = 0; inv_cur = 1'b1;
    do_start(6'd5);
    run_a(1100, 1'b0, 0, pulses);
    check("inv_locked", a_locked, 1);
    check("inv_inverted", a_inverted, 1);
    check("inv_corr", a_corr, 0);

    // PRN1 input while searching PRN2 on the four-slip instance
    make_code(1, code_cur); delay_cur = 0; inv_cur = 1'b0;
    do_start(6'd2);
    pulses = 0; inrange = 0; n = 0;
    while (!b_fail && n < 6000) begin
      chip_valid = 1'b1;
      chip_in    = stream_chip(sidx);
      tick();
      sidx++;
      n++;
      if (b_corr_valid) begin
        pulses++;
        if (b_corr > 11'd123 && b_corr < 11'd900) inrange++;
      end
    end
    chip_valid = 1'b0;
    check("ms4_chips", n, 5 * 1023 + 4);
    check("ms4_pulses", pulses, 5);
    check("ms4_corr_between", inrange, 5);
    check("ms4_fail", b_fail, 1);
    check("ms4_busy", b_busy, 0);
    check("ms4_locked", b_locked, 0);
    check("ms4_code_phase", b_code_phase, 4);
    repeat (3) tick();
    check("ms4_fail_sticky", b_fail, 1);

    // Invalid prn
    start = 1'b1; prn = 6'd0;
    tick();
    start = 1'b0;
    check("prn0_fail", a_fail, 1);
    check("prn0_busy", a_busy, 0);
    start = 1'b1; prn = 6'd33;
    tick();
    start = 1'b0;
    check("prn33_fail", a_fail, 1);

    // Lock on PRN31, then input switches to PRN1
    make_code(31, code_cur); delay_cur = 0; inv_cur = 1'b0;
    do_start(6'd31);
    check("restart_fail_clr", a_fail, 0);
    run_a(1100, 1'b0, 0, pulses);
    check("sw_locked", a_locked, 1);
    make_code(1, code_cur);
    run_a(1100, 1'b0, 1, pulses);
    check("sw_pulse", a_corr_valid, 1);
    check("sw_unlocked", a_locked, 0);
    check("sw_phase_before", a_code_phase, 0);
    check("sw_busy", a_busy, 1);
    chip_valid = 1'b1;
    chip_in    = stream_chip(sidx);
    tick();
    chip_valid = 1'b0;
    check("sw_phase_after", a_code_phase, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ca_code_search.md
# ca_code_search

Serial code-phase search and lock block for one GPS L1 C/A PRN. It is the receive-side counterpart of the C/A chip generator. It consumes a hard-decision chip stream, regenerates the local Gold-code replica for the requested PRN (PRN 1..32), and correlates over full 1023-chip periods. After each failed period it slips the replica by one chip, until the correlation magnitude crosses a threshold or the search budget is exhausted. The block sits between the front-end chip slicer and the tracking/navigation logic.

## Interface
- LOCK_THRESH, 900: agreement count (out of 1023) required for lock; the inverted-lock test uses 1023-LOCK_THRESH.
- MAX_SLIPS, 1023: number of slips after which a failing period ends the search.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a search for `prn`; accepted in any state.
- prn  in  6  satellite number, sampled only on `start`.
- chip_valid  in  1  qualifies `chip_in`.
- chip_in  in  1  received chip (1/0).
- busy  out  1  high in LOAD, CORR, SLIP and LOCKED.
- locked  out  1  replica aligned.
- inverted  out  1  lock was achieved on the complemented code (data bit = 1).
- fail  out  1  search ended without lock, or `prn` was invalid; sticky until `start` or `rst`.
- code_phase  out  10  slips performed so far, equal to the input delay in chips.
- corr  out  11  agreement count of the last completed period.
- corr_valid  out  1  one-cycle pulse at the end of each period.
- local_chip  out  1  current replica chip (debug).

## Operation
- Replica generation:
  - G1 shift: {g1[9:1], g1[3]^g1[10]}.
  - G2 shift: {g2[9:1], g2[2]^g2[3]^g2[6]^g2[8]^g2[9]^g2[10]}.
  - Both registers are loaded to all ones.
  - Chip = g1[10]^g2[t1]^g2[t2], using the standard IS-GPS-200 tap pairs for PRN 1..32. Examples: PRN1 (2,6), PRN2 (3,7), PRN31 (3,8).
  - The registers advance only on a counted chip.
- States: IDLE, LOAD, CORR, SLIP, LOCKED, FAIL.
- IDLE:
  - `start` with `prn` in 1..32 → LOAD.
  - `start` with any other `prn` → FAIL.
- LOAD (one cycle):
  - Latch the taps.
  - G1 = G2 = all ones.
  - chip_cnt = 0, agree = 0, slips = 0.
  - → CORR.
- CORR, on each `chip_valid`:
  - agree += (chip_in == local_chip).
  - Advance both LFSRs; chip_cnt += 1.
  - On the 1023rd chip: pulse `corr_valid` and load `corr` with the final agree, then evaluate.
- Evaluation at the end of a period:
  - agree ≥ LOCK_THRESH → LOCKED, inverted = 0.
  - agree ≤ 1023-LOCK_THRESH → LOCKED, inverted = 1.
  - Neither, and slips == MAX_SLIPS → FAIL.
  - Neither otherwise → SLIP.
- chip_cnt and agree clear at the start of every period. The LFSRs are naturally back at all ones after 1023 advances.
- SLIP:
  - Wait for the next `chip_valid`, discard that chip, and do not advance the LFSRs. This delays the replica by one chip.
  - slips += 1, code_phase = slips.
  - → CORR.
- LOCKED:
  - Keep correlating period by period; `corr_valid` pulses at every period end.
  - If a period fails the lock test (with the same polarity rule), deassert `locked` and go to SLIP, keeping the slips count.
  - If slips == MAX_SLIPS at that point → FAIL.
- FAIL: hold until `start`.
- `start` in any state restarts the search: IDLE path, then LOAD.
- `rst` in any state → IDLE.
- Widths:
  - agree and chip_cnt are 11 bits and never exceed 1023.
  - slips is 10 bits and saturates at MAX_SLIPS.

## Timing
- Reset values: busy = locked = inverted = fail = corr_valid = 0, code_phase = 0, corr = 0. local_chip = 0 in IDLE, then the replica chip once LOAD has run.
- All outputs are registered.
- `start` at cycle N: LOAD at N+1, CORR from N+2. Chips with `chip_valid` in cycles ≤ N+1 are ignored.
- Invalid `prn`: `fail` = 1 at cycle N+1.
- `corr_valid`, `corr`, `locked`, `inverted` and `fail` all update in the cycle after the 1023rd counted chip is sampled.
- Gaps in `chip_valid` stall the block without affecting results.
- Input delayed by D chips (the first D chips arbitrary, then the PRN from all ones): lock occurs after D·1024+1023 counted or discarded chips, with code_phase = D.

## Test plan
- Reset: assert `rst` mid-CORR → next cycle all outputs at reset values, state IDLE; a new `start` searches normally.
- Aligned PRN31 stream, `start` prn=31 → `corr_valid` after 1023 chips with corr=1023, locked=1, inverted=0, code_phase=0.
- PRN2 stream delayed by D=5, `chip_valid` asserted every other cycle → locked=1, code_phase=5, corr=1023, five `corr_valid` pulses before lock.
- Complemented aligned PRN5 stream → locked=1, inverted=1, corr=0.
- PRN1 stream while searching PRN2 with MAX_SLIPS=4 → five periods, corr never within the lock thresholds, fail=1, busy=0, locked=0.
- `start` prn=0 → fail=1 next cycle. Locked on PRN31, then switch the input to PRN1 → `locked` drops at that period's end, and code_phase increments.
